// File: rtl/parking_display_scanner_pkg.sv
// rtl/parking_display_scanner_pkg.sv - shared constants and position index for the parking display scanner
// Purpose: blank code, number of scanned positions, position enum and its wrap-around successor.
// Ports: none (package).
package pkg_parking;

   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam int         NUM_POS    = 6;

   typedef enum logic [2:0] {
      POS_FSYM = 3'd0,
      POS_FT   = 3'd1,
      POS_FU   = 3'd2,
      POS_BSYM = 3'd3,
      POS_BT   = 3'd4,
      POS_BU   = 3'd5
   } pos_e;

   function automatic pos_e next_pos(input pos_e p);
      return (p == POS_BU) ? POS_FSYM : pos_e'(p + 3'd1);
   endfunction

endpackage

// File: rtl/parking_display_scanner_bin2bcd2.sv
// rtl/parking_display_scanner_bin2bcd2.sv - combinational 0..99 binary to two-digit BCD
// Purpose: split a binary count into tens and units digits.
// Ports:
//   bin_i    in  7  binary value, 0..99
//   tens_o   out 4  tens digit
//   units_o  out 4  units digit
module bin2bcd2 (
   input  logic [6:0] bin_i,
   output logic [3:0] tens_o,
   output logic [3:0] units_o
);

   assign tens_o  = 4'(bin_i / 7'd10);
   assign units_o = 4'(bin_i % 7'd10);

endmodule

// File: rtl/parking_display_scanner.sv
// rtl/parking_display_scanner.sv - time-multiplexed 7-seg scanner for free/busy slot counts
// Purpose: synchronise slot sensors, snapshot busy/free counts once per frame and scan six
//          digit positions (F sym, free tens, free units, B sym, busy tens, busy units).
// Ports:
//   clk          in   1        system clock
//   rst_n        in   1        asynchronous active-low reset
//   en           in   1        scan enable
//   occupied     in   N_SLOTS  raw sensor inputs, 1 = slot busy
//   digit_code   out  4        code for the active position, 4'hF = blank
//   digit_sel_n  out  6        active-low one-hot digit enable
//   full         out  1        snapshot free count is zero
//   empty        out  1        snapshot busy count is zero
//   frame_start  out  1        one-cycle pulse when position 0 is entered
module parking_display_scanner
   import pkg_parking::*;
#(
   parameter int         N_SLOTS      = 4,
   parameter int         SCAN_DIV     = 50000,
   parameter int         BLINK_FRAMES = 64,
   parameter bit         LZ_BLANK     = 1'b1,
   parameter logic [3:0] FREE_SYM     = 4'b1001,
   parameter logic [3:0] BUSY_SYM     = 4'b1010
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [N_SLOTS-1:0] occupied,
   output logic [3:0]         digit_code,
   output logic [5:0]         digit_sel_n,
   output logic               full,
   output logic               empty,
   output logic               frame_start
);

   localparam int CW = $clog2(N_SLOTS + 1);
   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   if (N_SLOTS < 1 || N_SLOTS > 99) begin : g_bad_slots
      $error("N_SLOTS must be in 1..99");
   end
   if (SCAN_DIV < 2) begin : g_bad_div
      $error("SCAN_DIV must be >= 2");
   end
   if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("BLINK_FRAMES must be >= 1");
   end

   logic [N_SLOTS-1:0] sync1_q, sync2_q;
   logic [PW-1:0]      presc_q, presc_d;
   pos_e               idx_q, idx_d;
   logic [CW-1:0]      snap_busy_q, snap_busy_d, snap_free_q, snap_free_d;
   logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
   logic               phase_q, phase_d;
   logic               full_q, full_d, empty_q, empty_d;
   logic               frame_start_q, frame_start_d;
   logic [3:0]         digit_code_q, digit_code_d;
   logic [NUM_POS-1:0] digit_sel_n_q, digit_sel_n_d;

   logic [CW-1:0] busy, free;
   logic [3:0]    free_tens, free_units, busy_tens, busy_units;
   logic          tick, frame_wrap, blink;

   always_comb begin
      busy = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         busy = busy + CW'(sync2_q[i]);
      end
   end
   assign free = CW'(N_SLOTS) - busy;

   bin2bcd2 u_free_bcd (.bin_i(7'(snap_free_q)), .tens_o(free_tens), .units_o(free_units));
   bin2bcd2 u_busy_bcd (.bin_i(7'(snap_busy_q)), .tens_o(busy_tens), .units_o(busy_units));

   assign tick       = en && (presc_q == PW'(SCAN_DIV - 1));
   assign frame_wrap = tick && (idx_q == POS_BU);
   assign blink      = full_q && phase_q;

   always_comb begin
      presc_d       = presc_q;
      idx_d         = idx_q;
      snap_busy_d   = snap_busy_q;
      snap_free_d   = snap_free_q;
      frame_cnt_d   = frame_cnt_q;
      phase_d       = phase_q;
      full_d        = full_q;
      empty_d       = empty_q;
      frame_start_d = 1'b0;
      digit_code_d  = digit_code_q;
      digit_sel_n_d = digit_sel_n_q;

      if (en) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
         idx_d = next_pos(idx_q);
      end

      if (frame_wrap) begin
         snap_busy_d   = busy;
         snap_free_d   = free;
         full_d        = (free == '0);
         empty_d       = (busy == '0);
         frame_start_d = 1'b1;
         // Blink timing restarts from phase 0 each time the lot becomes full,
         // and stops immediately when it is no longer full.
         if (!full_q || free != '0) begin
            frame_cnt_d = '0;
            phase_d     = 1'b0;
         end else if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end

      // Codes for idx 1..5 use the snapshot taken when idx 0 was entered.
      if (!en) begin
         digit_code_d  = BLANK_CODE;
         digit_sel_n_d = '1;
      end else if (tick) begin
         digit_sel_n_d = ~(NUM_POS'(1) << idx_d);
         case (idx_d)
            POS_FSYM: digit_code_d = FREE_SYM;
            POS_FT:   digit_code_d = (blink || (LZ_BLANK && free_tens == 4'd0)) ? BLANK_CODE : free_tens;
            POS_FU:   digit_code_d = blink ? BLANK_CODE : free_units;
            POS_BSYM: digit_code_d = BUSY_SYM;
            POS_BT:   digit_code_d = (LZ_BLANK && busy_tens == 4'd0) ? BLANK_CODE : busy_tens;
            POS_BU:   digit_code_d = busy_units;
            default:  digit_code_d = BLANK_CODE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         presc_q       <= '0;
         idx_q         <= POS_BU;
         snap_busy_q   <= '0;
         snap_free_q   <= '0;
         frame_cnt_q   <= '0;
         phase_q       <= 1'b0;
         full_q        <= 1'b0;
         empty_q       <= 1'b0;
         frame_start_q <= 1'b0;
         digit_code_q  <= BLANK_CODE;
         digit_sel_n_q <= '1;
      end else begin
         sync1_q       <= occupied;
         sync2_q       <= sync1_q;
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         snap_busy_q   <= snap_busy_d;
         snap_free_q   <= snap_free_d;
         frame_cnt_q   <= frame_cnt_d;
         phase_q       <= phase_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         frame_start_q <= frame_start_d;
         digit_code_q  <= digit_code_d;
         digit_sel_n_q <= digit_sel_n_d;
      end
   end

   assign digit_code  = digit_code_q;
   assign digit_sel_n = digit_sel_n_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_parking_display_scanner.sv
// tb/tb_parking_display_scanner.sv - self-checking bench for parking_display_scanner
module tb_parking_display_scanner;

   localparam int SD = 4;
   localparam int BF = 2;
   localparam int NA = 4;
   localparam int NB = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en_a, en_b;
   logic [NA-1:0] occ_a;
   logic [NB-1:0] occ_b;
   logic [3:0]    code_a, code_b;
   logic [5:0]    sel_a, sel_b;
   logic          full_a, empty_a, fs_a, full_b, empty_b, fs_b;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state for instance A
   logic [NA-1:0] occ_settled;
   int            m_busy;
   bit            m_full, m_full_prev, m_blink;
   int            m_k;

   always #5 clk = ~clk;

   parking_display_scanner #(
      .N_SLOTS(NA), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(1'b1),
      .FREE_SYM(4'b1001), .BUSY_SYM(4'b1010)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .occupied(occ_a),
      .digit_code(code_a), .digit_sel_n(sel_a), .full(full_a), .empty(empty_a),
      .frame_start(fs_a)
   );

   parking_display_scanner #(
      .N_SLOTS(NB), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(1'b0),
      .FREE_SYM(4'b1001), .BUSY_SYM(4'b1010)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .occupied(occ_b),
      .digit_code(code_b), .digit_sel_n(sel_b), .full(full_b), .empty(empty_b),
      .frame_start(fs_b)
   );

   always @(negedge clk) begin
      vectors++;
      if ($countones(~sel_a) > 1 || $countones(~sel_b) > 1) begin
         miscompares++;
         $display("FAIL sel_onehot got a=%b b=%b want at most one low bit", sel_a, sel_b);
      end
   end

   function automatic logic [3:0] exp_code(input int n, input int busy, input bit lz,
                                           input bit blink, input int pos);
      int fr;
      fr = n - busy;
      case (pos)
         0: return 4'h9;
         1: return (blink || (lz && fr / 10 == 0)) ? 4'hF : 4'(fr / 10);
         2: return blink ? 4'hF : 4'(fr % 10);
         3: return 4'hA;
         4: return (lz && busy / 10 == 0) ? 4'hF : 4'(busy / 10);
         5: return 4'(busy % 10);
         default: return 4'hF;
      endcase
   endfunction

   task automatic model_frame_start();
      m_busy = $countones(occ_settled);
      m_full = (m_busy == NA);
      if (m_full) m_k = m_full_prev ? m_k + 1 : 0;
      m_blink     = m_full && ((m_k / BF) % 2 == 1);
      m_full_prev = m_full;
   endtask

   task automatic wait_frame_a(output int waited);
      waited = 0;
      while (fs_a !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (fs_a !== 1'b1) begin
         miscompares++;
         $display("FAIL frame_start_timeout got=%b want=1", fs_a);
      end
   endtask

   // Checks one full frame of A; mid-frame glitches then settles occupied to next_occ.
   task automatic run_frame_a(input logic [NA-1:0] next_occ, input int change_at, input bit b2b);
      int waited;
      int pos;
      logic [5:0] esel;
      logic [3:0] ecode;
      wait_frame_a(waited);
      if (b2b) begin
         vectors++;
         if (waited != 0) begin
            miscompares++;
            $display("FAIL frame_period got=%0d extra cycles want=0", waited);
         end
      end
      model_frame_start();
      vectors++;
      if (full_a !== m_full) begin
         miscompares++;
         $display("FAIL full got=%b want=%b", full_a, m_full);
      end
      vectors++;
      if (empty_a !== (m_busy == 0)) begin
         miscompares++;
         $display("FAIL empty got=%b want=%b", empty_a, (m_busy == 0));
      end
      for (int cyc = 0; cyc < 6 * SD; cyc++) begin
         pos   = cyc / SD;
         esel  = ~(6'(1) << pos);
         ecode = exp_code(NA, m_busy, 1'b1, m_blink, pos);
         vectors++;
         if (sel_a !== esel) begin
            miscompares++;
            $display("FAIL sel cyc=%0d got=%b want=%b", cyc, sel_a, esel);
         end
         vectors++;
         if (code_a !== ecode) begin
            miscompares++;
            $display("FAIL code pos=%0d busy=%0d got=%h want=%h", pos, m_busy, code_a, ecode);
         end
         vectors++;
         if (fs_a !== (cyc == 0)) begin
            miscompares++;
            $display("FAIL frame_start_pulse cyc=%0d got=%b want=%b", cyc, fs_a, (cyc == 0));
         end
         if (cyc == change_at) occ_a = NA'($urandom);
         if (cyc == change_at + 1) begin
            occ_a       = next_occ;
            occ_settled = next_occ;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_reset_values(input string tag);
      vectors++;
      if (code_a !== 4'hF) begin miscompares++; $display("FAIL %s_code got=%h want=f", tag, code_a); end
      vectors++;
      if (sel_a !== 6'b111111) begin miscompares++; $display("FAIL %s_sel got=%b want=111111", tag, sel_a); end
      vectors++;
      if (full_a !== 1'b0) begin miscompares++; $display("FAIL %s_full got=%b want=0", tag, full_a); end
      vectors++;
      if (empty_a !== 1'b0) begin miscompares++; $display("FAIL %s_empty got=%b want=0", tag, empty_a); end
      vectors++;
      if (fs_a !== 1'b0) begin miscompares++; $display("FAIL %s_fs got=%b want=0", tag, fs_a); end
   endtask

   task automatic release_and_check_latency();
      int n;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (fs_a !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n != SD) begin
         miscompares++;
         $display("FAIL first_tick_latency got=%0d want=%0d", n, SD);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
   endtask

   task automatic test_first_frame();
      release_and_check_latency();
      run_frame_a(4'b1011, 5, 1'b1);
   endtask

   task automatic test_busy_pattern();
      run_frame_a(4'b1111, 7, 1'b1);
   endtask

   task automatic test_full_blink();
      run_frame_a(4'b1111, 3, 1'b1);
      run_frame_a(4'b1111, 9, 1'b1);
      run_frame_a(4'b1111, 12, 1'b1);
      run_frame_a(4'b1110, 15, 1'b1);
      run_frame_a(4'b1110, 2, 1'b1);
   endtask

   task automatic test_wide_slots();
      int busy_b;
      int n;
      logic [NB-1:0] v;
      for (int t = 0; t < 3; t++) begin
         busy_b = (t == 0) ? 10 : int'($urandom_range(0, NB - 1));
         v = '0;
         while ($countones(v) < busy_b) v[$urandom_range(0, NB - 1)] = 1'b1;
         n = 0;
         while (fs_b !== 1'b1 && n < 200) begin @(negedge clk); n++; end
         @(negedge clk);
         occ_b = v;
         n = 0;
         while (fs_b !== 1'b1 && n < 200) begin @(negedge clk); n++; end
         vectors++;
         if (fs_b !== 1'b1) begin miscompares++; $display("FAIL wide_frame_timeout got=%b want=1", fs_b); end
         vectors++;
         if (empty_b !== (busy_b == 0)) begin
            miscompares++;
            $display("FAIL wide_empty got=%b want=%b", empty_b, (busy_b == 0));
         end
         for (int pos = 0; pos < 6; pos++) begin
            vectors++;
            if (code_b !== exp_code(NB, busy_b, 1'b0, 1'b0, pos)) begin
               miscompares++;
               $display("FAIL wide_code pos=%0d busy=%0d got=%h want=%h", pos, busy_b, code_b,
                        exp_code(NB, busy_b, 1'b0, 1'b0, pos));
            end
            vectors++;
            if (sel_b !== ~(6'(1) << pos)) begin
               miscompares++;
               $display("FAIL wide_sel pos=%0d got=%b want=%b", pos, sel_b, ~(6'(1) << pos));
            end
            repeat (SD) @(negedge clk);
         end
      end
   endtask

   task automatic test_random_frames();
      run_frame_a(NA'($urandom), int'($urandom_range(1, 19)), 1'b0);
      for (int f = 0; f < 9; f++) begin
         run_frame_a(NA'($urandom), int'($urandom_range(1, 19)), 1'b1);
      end
   endtask

   task automatic test_enable_pause();
      int waited;
      int p, c, n;
      for (int it = 0; it < 2; it++) begin
         wait_frame_a(waited);
         model_frame_start();
         p = int'($urandom_range(0, 4));
         c = int'($urandom_range(0, SD - 1));
         repeat (p * SD + c) @(negedge clk);
         en_a = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (sel_a !== 6'b111111 || code_a !== 4'hF) begin
               miscompares++;
               $display("FAIL en_off k=%0d got sel=%b code=%h want sel=111111 code=f", k, sel_a, code_a);
            end
         end
         en_a = 1'b1;
         n = 0;
         while (sel_a === 6'b111111 && n < 20) begin @(negedge clk); n++; end
         vectors++;
         if (n != SD - c) begin
            miscompares++;
            $display("FAIL resume_delay got=%0d want=%0d", n, SD - c);
         end
         vectors++;
         if (sel_a !== ~(6'(1) << (p + 1))) begin
            miscompares++;
            $display("FAIL resume_sel got=%b want=%b", sel_a, ~(6'(1) << (p + 1)));
         end
         vectors++;
         if (code_a !== exp_code(NA, m_busy, 1'b1, m_blink, p + 1)) begin
            miscompares++;
            $display("FAIL resume_code got=%h want=%h", code_a, exp_code(NA, m_busy, 1'b1, m_blink, p + 1));
         end
      end
   endtask

   task automatic test_reset_midscan();
      int waited;
      wait_frame_a(waited);
      repeat (3 * SD + 1) @(negedge clk);
      vectors++;
      if (sel_a !== 6'b110111) begin
         miscompares++;
         $display("FAIL midscan_pos got=%b want=110111", sel_a);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      repeat (2) @(negedge clk);
      occ_a       = NA'($urandom);
      occ_settled = occ_a;
      m_full_prev = 1'b0;
      m_k         = 0;
      release_and_check_latency();
      run_frame_a(occ_a, 6, 1'b1);
   endtask

   initial begin
      rst_n       = 1'b0;
      en_a        = 1'b1;
      en_b        = 1'b1;
      occ_a       = '0;
      occ_b       = '0;
      occ_settled = '0;
      m_full_prev = 1'b0;
      m_k         = 0;
      m_busy      = 0;
      m_full      = 1'b0;
      m_blink     = 1'b0;
      test_reset();
      test_first_frame();
      test_busy_pattern();
      test_full_blink();
      test_wide_slots();
      test_random_frames();
      test_enable_pause();
      test_reset_midscan();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
